wiper_ctrl: RTL

WIPER_CTRL -- requirements
Module: wiper_ctrl

---
 rtl/wiper_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wiper_ctrl.sv
// wiper_ctrl: rain-sensing wiper FSM; define WIPER_MIST_EN to add the single mist-wipe feature.
// Latency: drop_cnt and wiper update one tick after sampling; no backpressure (tick-strobed state).
module wiper_ctrl #(
  parameter int NSENS      = 7,
  parameter int THR_SLOW   = 3,
  parameter int THR_FAST   = 5,
  parameter int DWELL_SLOW = 3,
  parameter int DWELL_FAST = 2,
  parameter int HOLD_OFF   = 4,
  parameter int MIST_TICKS = 6
) (
  input  logic                       clk_2,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic [NSENS-1:0]           sensors,
  input  logic [1:0]                 mode,
  input  logic                       mist_req,
  output logic [1:0]                 wiper,
  output logic [$clog2(NSENS+1)-1:0] drop_cnt
);

  localparam int DW    = $clog2(NSENS + 1);
  localparam int DMAX0 = (DWELL_SLOW > DWELL_FAST) ? DWELL_SLOW : DWELL_FAST;
  localparam int DMAX  = (DMAX0 > HOLD_OFF) ? DMAX0 : HOLD_OFF;
  localparam int CW    = $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_SLOW = 2'b01,
    ST_FAST = 2'b10,
    ST_MIST = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d, pop;
  logic [CW-1:0] run_act_q, run_act_d;
  logic [CW-1:0] run_hi_q, run_hi_d;
  logic [CW-1:0] run_nhi_q, run_nhi_d;
  logic [CW-1:0] run_lo_q, run_lo_d;
  logic          cls_act, cls_hi;
  logic          act_ok, hi_ok, nhi_hold, lo_hold;

`ifdef WIPER_MIST_EN
  localparam int MW = $clog2(MIST_TICKS + 1);
  logic [MW-1:0] mist_q, mist_d;
`else
  localparam int mist_ticks_unused = MIST_TICKS;
  logic          mist_req_unused;
  assign mist_req_unused = mist_req;
`endif

  function automatic logic [CW-1:0] run_next(input logic [CW-1:0] c, input logic en);
    if (!en)
      return '0;
    return (c == '1) ? c : c + CW'(1);
  endfunction

  always_comb begin
    pop = '0;
    for (int i = 0; i < NSENS; i++)
      pop = pop + DW'(sensors[i]);
  end

  // Classification uses the previously registered count, not the live sensors.
  assign cls_hi  = int'(drop_cnt_q) >= THR_FAST;
  assign cls_act = int'(drop_cnt_q) >= THR_SLOW;

  assign hi_ok    = int'(run_hi_q)  >= DWELL_FAST;
  assign act_ok   = int'(run_act_q) >= DWELL_SLOW;
  assign nhi_hold = int'(run_nhi_q) >= HOLD_OFF;
  assign lo_hold  = int'(run_lo_q)  >= HOLD_OFF;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    run_act_d  = run_act_q;
    run_hi_d   = run_hi_q;
    run_nhi_d  = run_nhi_q;
    run_lo_d   = run_lo_q;
    if (tick) begin
      drop_cnt_d = pop;
      run_act_d  = run_next(run_act_q, cls_act);
      run_hi_d   = run_next(run_hi_q, cls_hi);
      run_nhi_d  = run_next(run_nhi_q, !cls_hi);
      run_lo_d   = run_next(run_lo_q, !cls_act);
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef WIPER_MIST_EN
    mist_d  = mist_q;
`endif
    if (tick) begin
      case (mode)
        2'b01:   state_d = ST_OFF;
        2'b10:   state_d = ST_SLOW;
        2'b11:   state_d = ST_FAST;
        default: begin
          case (state_q)
            ST_OFF: begin
`ifdef WIPER_MIST_EN
              if (mist_req) begin
                state_d = ST_MIST;
                mist_d  = MW'(MIST_TICKS - 1);
              end else
`endif
              if (hi_ok)
                state_d = ST_FAST;
              else if (act_ok)
                state_d = ST_SLOW;
            end
            ST_SLOW: begin
              if (hi_ok)
                state_d = ST_FAST;
              else if (lo_hold)
                state_d = ST_OFF;
            end
            ST_FAST: begin
              if (lo_hold)
                state_d = ST_OFF;
              else if (nhi_hold)
                state_d = ST_SLOW;
            end
            ST_MIST: begin
`ifdef WIPER_MIST_EN
              // Counter holds remaining ticks after the current one.
              if (mist_q == '0)
                state_d = ST_OFF;
              else
                mist_d = mist_q - MW'(1);
`else
              state_d = ST_OFF;
`endif
            end
            default: state_d = ST_OFF;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      drop_cnt_q <= '0;
      run_act_q  <= '0;
      run_hi_q   <= '0;
      run_nhi_q  <= '0;
      run_lo_q   <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      run_act_q  <= run_act_d;
      run_hi_q   <= run_hi_d;
      run_nhi_q  <= run_nhi_d;
      run_lo_q   <= run_lo_d;
    end
  end

`ifdef WIPER_MIST_EN
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n)
      mist_q <= '0;
    else
      mist_q <= mist_d;
  end
`endif

  assign wiper    = state_q;
  assign drop_cnt = drop_cnt_q;

endmodule
